// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a word-aligned pc through instruction memory and
// buffers fetched {instr, pc} pairs in a 2-entry queue for a ready/valid consumer.
module fetch_sequencer #(
    parameter logic [10:0] RESET_PC     = 11'h000,
    parameter bit          HALT_ON_NULL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [10:0] out_pc,
    input  logic        redirect_valid,
    input  logic [10:0] redirect_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [10:0] PC_ALIGN_MASK = 11'h7FC;
    localparam logic [10:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    state_t      state;
    state_t      state_next;
    logic [10:0] pc;
    logic [10:0] pc_next;
    logic [1:0]  count;
    logic [1:0]  count_next;

    logic [31:0] head_instr;
    logic [10:0] head_pc;
    logic [31:0] tail_instr;
    logic [10:0] tail_pc;

    logic        flush;
    logic        deq;
    logic        can_accept;
    logic        null_word;
    logic        enq;

    assign imem_addr = pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = head_instr;
    assign out_pc    = head_pc;
    assign halted    = (state == HALT);

    // A redirect outranks everything: it flushes the queue and blocks both handshake and fetch.
    always_comb begin
        flush      = redirect_valid && (state != IDLE);
        deq        = out_valid && out_ready && !flush;
        can_accept = (count != 2'd2) || deq;
        null_word  = HALT_ON_NULL && (imem_instr == 32'd0);
        enq        = (state == FETCH) && !flush && can_accept && !null_word;
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (flush) begin
                    pc_next = redirect_pc & PC_ALIGN_MASK;
                end else if (can_accept && null_word) begin
                    state_next = HALT;
                end else if (enq) begin
                    pc_next = pc + 11'd4;
                end
            end
            HALT: begin
                if (flush) begin
                    state_next = FETCH;
                    pc_next    = redirect_pc & PC_ALIGN_MASK;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else if (enq && !deq) begin
            count_next = count + 2'd1;
        end else if (deq && !enq) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC_ALIGNED;
            count <= 2'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            count <= count_next;
        end
    end

    // Shift-style queue: the head slot only changes when a new head appears, so the
    // outputs keep their last values once the queue drains or is flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_instr <= 32'd0;
            head_pc    <= 11'd0;
            tail_instr <= 32'd0;
            tail_pc    <= 11'd0;
        end else if (!flush) begin
            if (enq && !deq) begin
                if (count == 2'd0) begin
                    head_instr <= imem_instr;
                    head_pc    <= pc;
                end else begin
                    tail_instr <= imem_instr;
                    tail_pc    <= pc;
                end
            end else if (deq && !enq) begin
                if (count == 2'd2) begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                end
            end else if (enq && deq) begin
                if (count == 2'd1) begin
                    head_instr <= imem_instr;
                    head_pc    <= pc;
                end else begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    tail_instr <= imem_instr;
                    tail_pc    <= pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'd0;
        end else if (deq) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a queue-based model checked every negedge, plus directed
// vectors with hand-computed expectations for start-up, stall, redirect, halt, wrap and reset.
module tb_fetch_sequencer;

    localparam logic [10:0] RESET_PC     = 11'h000;
    localparam bit          HALT_ON_NULL = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [10:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [10:0] out_pc;
    logic        redirect_valid;
    logic [10:0] redirect_pc;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:511];

    typedef struct packed {
        logic [31:0] instr;
        logic [10:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [10:0] m_pc      = RESET_PC;
    bit          m_started = 1'b0;
    bit          m_halted  = 1'b0;
    logic [15:0] m_count   = 16'd0;

    fetch_sequencer #(
        .RESET_PC    (RESET_PC),
        .HALT_ON_NULL(HALT_ON_NULL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    assign imem_instr = mem[imem_addr[10:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle with the given inputs; returns 2 time units after the edge that sampled them.
    task automatic apply_stimulus(input bit rdy, input bit rv, input logic [10:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #2;
    endtask

    // Model: the queue holds what the consumer should see, in order; at most two entries.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_pc      = RESET_PC & 11'h7FC;
                m_started = 1'b0;
                m_halted  = 1'b0;
                m_count   = 16'd0;
            end else if (!m_started) begin
                m_started = 1'b1;
            end else if (redirect_valid) begin
                mq.delete();
                m_pc     = {redirect_pc[10:2], 2'b00};
                m_halted = 1'b0;
            end else begin
                if (mq.size() != 0 && out_ready) begin
                    void'(mq.pop_front());
                    m_count = m_count + 16'd1;
                end
                if (!m_halted && mq.size() < 2) begin
                    if (HALT_ON_NULL && mem[m_pc[10:2]] == 32'd0) begin
                        m_halted = 1'b1;
                    end else begin
                        mq.push_back({mem[m_pc[10:2]], m_pc});
                        m_pc = m_pc + 11'd4;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_output("model_imem_addr", 32'(imem_addr), 32'(m_pc));
            check_output("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check_output("model_halted", 32'(halted), 32'(m_halted));
            check_output("model_fetch_count", 32'(fetch_count), 32'(m_count));
            if (mq.size() != 0) begin
                check_output("model_out_pc", 32'(out_pc), 32'(mq[0].pc));
                check_output("model_out_instr", out_instr, mq[0].instr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[34] = 32'd0;

        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 11'd0;

        repeat (2) @(posedge clk);
        #2;
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_imem_addr", 32'(imem_addr), 32'h000);
        check_output("reset_halted", 32'(halted), 32'd0);
        check_output("reset_fetch_count", 32'(fetch_count), 32'd0);
        check_output("reset_out_instr", out_instr, 32'd0);
        rst_n = 1'b1;

        // Free-running stream from reset until the null word at 0x088.
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("start_no_fetch", 32'(out_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("first_valid", 32'(out_valid), 32'd1);
        check_output("first_pc", 32'(out_pc), 32'h000);
        for (int k = 1; k <= 33; k++) begin
            apply_stimulus(1'b1, 1'b0, 11'd0);
            check_output("stream_pc", 32'(out_pc), 32'(k * 4));
        end
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("null_halted", 32'(halted), 32'd1);
        check_output("null_fetch_count", 32'(fetch_count), 32'd34);
        check_output("null_drained", 32'(out_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0, 11'd0);
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("halt_pc_hold", 32'(imem_addr), 32'h088);
        check_output("halt_stays", 32'(halted), 32'd1);

        // Leave HALT through a redirect.
        apply_stimulus(1'b1, 1'b1, 11'h044);
        check_output("halt_exit", 32'(halted), 32'd0);
        check_output("halt_exit_pc", 32'(imem_addr), 32'h044);
        check_output("halt_exit_count", 32'(fetch_count), 32'd34);
        apply_stimulus(1'b0, 1'b0, 11'd0);
        check_output("halt_exit_instr", out_instr, 32'h1000_0011);
        check_output("halt_exit_out_pc", 32'(out_pc), 32'h044);

        // Asynchronous reset between edges while the queue holds an entry.
        #4;
        rst_n = 1'b0;
        #1;
        check_output("async_out_valid", 32'(out_valid), 32'd0);
        check_output("async_imem_addr", 32'(imem_addr), 32'(RESET_PC));
        check_output("async_fetch_count", 32'(fetch_count), 32'd0);
        check_output("async_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Redirect in the first cycle is ignored; then stall the consumer for 5 cycles.
        apply_stimulus(1'b0, 1'b1, 11'h100);
        check_output("idle_ignores_redirect", 32'(imem_addr), 32'h000);
        repeat (4) apply_stimulus(1'b0, 1'b0, 11'd0);
        check_output("stall_out_pc", 32'(out_pc), 32'h000);
        check_output("stall_pc_hold", 32'(imem_addr), 32'h008);
        check_output("stall_valid", 32'(out_valid), 32'd1);
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("drain_pc_1", 32'(out_pc), 32'h004);
        check_output("drain_count_1", 32'(fetch_count), 32'd1);
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("drain_pc_2", 32'(out_pc), 32'h008);
        check_output("drain_count_2", 32'(fetch_count), 32'd2);

        // Redirect with a full queue and the consumer ready: flush wins.
        apply_stimulus(1'b1, 1'b1, 11'h032);
        check_output("redirect_flush", 32'(out_valid), 32'd0);
        check_output("redirect_pc_align", 32'(imem_addr), 32'h030);
        check_output("redirect_no_count", 32'(fetch_count), 32'd2);
        apply_stimulus(1'b0, 1'b0, 11'd0);
        check_output("redirect_first_pc", 32'(out_pc), 32'h030);
        check_output("redirect_first_instr", out_instr, 32'h1000_000C);
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("redirect_next_pc", 32'(out_pc), 32'h034);
        check_output("redirect_next_count", 32'(fetch_count), 32'd3);

        // pc wraps from the top of the address space.
        apply_stimulus(1'b0, 1'b1, 11'h7FE);
        check_output("wrap_target", 32'(imem_addr), 32'h7FC);
        apply_stimulus(1'b0, 1'b0, 11'd0);
        check_output("wrap_pc_top", 32'(out_pc), 32'h7FC);
        check_output("wrap_instr_top", out_instr, 32'h1000_01FF);
        apply_stimulus(1'b1, 1'b0, 11'd0);
        check_output("wrap_pc_zero", 32'(out_pc), 32'h000);
        check_output("wrap_imem_addr", 32'(imem_addr), 32'h004);
        check_output("wrap_count", 32'(fetch_count), 32'd4);
        repeat (3) apply_stimulus(1'b1, 1'b0, 11'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
